ant_packet_controller: RTL and testbench

ANT_PACKET_CONTROLLER -- requirements
Module: ant_packet_controller

---
 rtl/ant_pkg.sv | 16 +
 rtl/ant_port_encoder.sv | 16 +
 rtl/ant_packet_controller.sv | 111 +++++++++++
 tb/tb_ant_packet_controller.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/ant_pkg.sv
// ant_pkg: shared ant packet types and widths for the ant-colony router
package ant_pkg;
  localparam int N = 5;
  localparam int MAX_HOPS_PKG = 8;
  localparam int HOP_W = $clog2(MAX_HOPS_PKG + 1);
  typedef logic [N-1:0] node_t;
  typedef logic [HOP_W-1:0] hop_t;
  typedef enum logic {FORWARD, BACKWARD} ant_type_e;
  typedef struct packed {
    ant_type_e ant_type;
    node_t src;
    node_t dest;
    hop_t hop;
    node_t [MAX_HOPS_PKG-1:0] path;
  } ant_t;
endpackage

// File: rtl/ant_port_encoder.sv
// ant_port_encoder: one-hot port to index, and index back to one-hot
module ant_port_encoder
  import ant_pkg::*;
(
  input  node_t i_onehot,
  output node_t o_index,
  input  node_t i_index,
  output node_t o_onehot
);
  always_comb begin
    o_index = '0;
    for (int i = 0; i < N; i++)
      o_index = i_onehot[i] ? (o_index | node_t'(i)) : o_index;
  end
  assign o_onehot = node_t'(1) << i_index;
endmodule

// File: rtl/ant_packet_controller.sv
// ant_packet_controller: holds one ant, updates its path stack, drives the
// routing table and forwards, reflects or drops the ant
module ant_packet_controller
  import ant_pkg::*;
#(
  parameter int NODE_ID  = 0,
  parameter int MAX_HOPS = 8
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_ant_valid,
  output logic       o_ant_ready,
  input  ant_t       i_ant,
  input  node_t      i_in_port,
  output logic       o_ant_valid,
  input  logic       i_ant_ready,
  output ant_t       o_ant,
  output node_t      o_out_port,
  output logic       o_rt_update,
  output logic       o_rt_calculate_neighbor,
  output node_t      o_rt_dest,
  output node_t      o_rt_parent,
  input  node_t      i_rt_next_output,
  output logic [7:0] o_drop_count
);
  typedef enum logic [1:0] {IDLE, DECIDE, SEND, DROP} state_e;
  state_e state_q, state_d;
  ant_t ant_q, ant_d;
  node_t arr_q, port_q, port_d, in_idx, dec_idx, dec_onehot, top;
  logic [7:0] drop_q;
  logic is_fwd, at_dest, hop_max, hop_zero, calc, upd, no_route;
  ant_port_encoder u_enc (
    .i_onehot(i_in_port),
    .o_index (in_idx),
    .i_index (dec_idx),
    .o_onehot(dec_onehot)
  );
  assign is_fwd   = ant_q.ant_type == FORWARD;
  assign at_dest  = ant_q.dest == node_t'(NODE_ID);
  assign hop_max  = ant_q.hop >= hop_t'(MAX_HOPS);
  assign hop_zero = ant_q.hop == '0;
  assign calc     = state_q == DECIDE && is_fwd && !at_dest && !hop_max;
  assign upd      = state_q == DECIDE && !is_fwd && !hop_zero;
  assign no_route = i_rt_next_output == '0 || i_rt_next_output[0];
  always_comb begin
    top = '0;
    for (int i = 0; i < MAX_HOPS_PKG; i++)
      top = (ant_q.hop == hop_t'(i + 1)) ? ant_q.path[i] : top;
  end
  // A reflected forward ant returns on its arrival port; a backward ant pops its stack
  assign dec_idx = is_fwd ? arr_q : top;
  always_comb begin
    state_d = state_q;
    ant_d   = ant_q;
    port_d  = port_q;
    case (state_q)
      IDLE: begin
        state_d = i_ant_valid ? DECIDE : IDLE;
        ant_d   = i_ant_valid ? i_ant : ant_q;
      end
      DECIDE: begin
        if (is_fwd && at_dest) begin
          ant_d.ant_type = BACKWARD;
          port_d = dec_onehot;
          state_d = SEND;
        end else if (is_fwd && hop_max) begin
          state_d = DROP;
        end else if (is_fwd) begin
          for (int i = 0; i < MAX_HOPS_PKG; i++)
            if (ant_q.hop == hop_t'(i)) ant_d.path[i] = arr_q;
          ant_d.hop = ant_q.hop + 1'b1;
          port_d = i_rt_next_output;
          state_d = no_route ? DROP : SEND;
        end else if (hop_zero) begin
          state_d = DROP;
        end else begin
          ant_d.hop = ant_q.hop - 1'b1;
          port_d = dec_onehot;
          state_d = SEND;
        end
      end
      SEND: state_d = i_ant_ready ? IDLE : SEND;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      ant_q   <= '0;
      arr_q   <= '0;
      port_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      ant_q   <= ant_d;
      port_q  <= port_d;
      arr_q   <= (state_q == IDLE && i_ant_valid) ? in_idx : arr_q;
      drop_q  <= (state_q == DROP && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    end
  end
  // Ready is masked while reset is held so every output reads 0 in reset
  assign o_ant_ready             = state_q == IDLE && i_reset_n;
  assign o_ant_valid             = state_q == SEND;
  assign o_ant                   = ant_q;
  assign o_out_port              = port_q;
  assign o_rt_update             = upd;
  assign o_rt_calculate_neighbor = calc;
  assign o_rt_dest               = (calc || upd) ? ant_q.dest : '0;
  assign o_rt_parent             = (calc || upd) ? arr_q : '0;
  assign o_drop_count            = drop_q;
endmodule

// File: tb/tb_ant_packet_controller.sv
// tb_ant_packet_controller: directed and random ants against a rule-level model
module tb_ant_packet_controller;
  import ant_pkg::*;
  logic i_clk = 0, i_reset_n = 0, i_ant_valid = 0, i_ant_ready = 0;
  ant_t i_ant = '0, o_ant;
  node_t i_in_port = '0, i_rt_next_output = '0, o_out_port, o_rt_dest, o_rt_parent;
  logic o_ant_ready, o_ant_valid, o_rt_update, o_rt_calculate_neighbor;
  logic [7:0] o_drop_count;
  int checks = 0, errors = 0, exp_drops = 0;
  always #5 i_clk = ~i_clk;
  ant_packet_controller #(.NODE_ID(3), .MAX_HOPS(8)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_ant_valid(i_ant_valid), .o_ant_ready(o_ant_ready), .i_ant(i_ant), .i_in_port(i_in_port),
    .o_ant_valid(o_ant_valid), .i_ant_ready(i_ant_ready), .o_ant(o_ant), .o_out_port(o_out_port),
    .o_rt_update(o_rt_update), .o_rt_calculate_neighbor(o_rt_calculate_neighbor),
    .o_rt_dest(o_rt_dest), .o_rt_parent(o_rt_parent), .i_rt_next_output(i_rt_next_output),
    .o_drop_count(o_drop_count)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  function automatic ant_t mk(input ant_type_e t, input int d, input int h);
    mk = '0;
    mk.ant_type = t;
    mk.src = node_t'(1);
    mk.dest = node_t'(d);
    mk.hop = hop_t'(h);
  endfunction
  function automatic void model(input ant_t a, input node_t inp, input node_t ans,
      output bit drop, output ant_t o, output node_t port, output bit calc, output bit upd,
      output int parent);
    int h = int'(a.hop);
    parent = 0;
    for (int i = 0; i < N; i++) if (inp[i]) parent = i;
    o = a; drop = 0; calc = 0; upd = 0; port = '0;
    if (a.ant_type == FORWARD && int'(a.dest) == 3) begin
      o.ant_type = BACKWARD;
      port = inp;
    end else if (a.ant_type == FORWARD && h >= 8) drop = 1;
    else if (a.ant_type == FORWARD) begin
      calc = 1;
      o.path[h] = node_t'(parent);
      o.hop = hop_t'(h + 1);
      port = ans;
      drop = (ans == '0) || ans[0];
    end else if (h == 0) drop = 1;
    else begin
      upd = 1;
      o.hop = hop_t'(h - 1);
      port = node_t'(1 << int'(a.path[h - 1]));
    end
  endfunction
  task automatic send_ant(input ant_t a, input node_t inp, input node_t ans, input int stall);
    bit drop, calc, upd;
    ant_t eo;
    node_t ep;
    int par, n;
    model(a, inp, ans, drop, eo, ep, calc, upd, par);
    n = 0;
    while (!o_ant_ready && n < 20) begin @(negedge i_clk); n++; end
    check("idle_ready", 64'(o_ant_ready), 64'(1));
    @(negedge i_clk);
    i_ant_valid = 1; i_ant = a; i_in_port = inp; i_rt_next_output = ans; i_ant_ready = 0;
    @(posedge i_clk); #1;
    i_ant_valid = 0;
    check("decide_ready", 64'(o_ant_ready), 64'(0));
    check("decide_valid", 64'(o_ant_valid), 64'(0));
    check("calc", 64'(o_rt_calculate_neighbor), 64'(calc));
    check("upd", 64'(o_rt_update), 64'(upd));
    if (calc || upd) begin
      check("rt_dest", 64'(o_rt_dest), 64'(a.dest));
      check("rt_parent", 64'(o_rt_parent), 64'(par));
    end
    @(posedge i_clk); #1;
    i_rt_next_output = node_t'($urandom);
    check("cmd_idle", 64'({o_rt_update, o_rt_calculate_neighbor}), 64'(0));
    if (drop) begin
      check("drop_valid", 64'(o_ant_valid), 64'(0));
      @(posedge i_clk); #1;
      exp_drops = exp_drops < 255 ? exp_drops + 1 : 255;
      check("drop_count", 64'(o_drop_count), 64'(exp_drops));
      check("drop_valid2", 64'(o_ant_valid), 64'(0));
      check("drop_ready", 64'(o_ant_ready), 64'(1));
    end else begin
      check("send_valid", 64'(o_ant_valid), 64'(1));
      check("send_ant", 64'(o_ant), 64'(eo));
      check("send_port", 64'(o_out_port), 64'(ep));
      for (int s = 0; s < stall; s++) begin
        @(posedge i_clk); #1;
        check("stall_valid", 64'(o_ant_valid), 64'(1));
        check("stall_ant", 64'(o_ant), 64'(eo));
        check("stall_port", 64'(o_out_port), 64'(ep));
        check("stall_ready", 64'(o_ant_ready), 64'(0));
      end
      i_ant_ready = 1;
      @(posedge i_clk); #1;
      i_ant_ready = 0;
      check("done_valid", 64'(o_ant_valid), 64'(0));
      check("done_ready", 64'(o_ant_ready), 64'(1));
      check("send_drops", 64'(o_drop_count), 64'(exp_drops));
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end
  initial begin
    ant_t a;
    node_t inp, ans;
    #1;
    check("rst_ready", 64'(o_ant_ready), 64'(0));
    check("rst_valid", 64'(o_ant_valid), 64'(0));
    check("rst_port", 64'(o_out_port), 64'(0));
    check("rst_drops", 64'(o_drop_count), 64'(0));
    @(negedge i_clk); @(negedge i_clk);
    i_reset_n = 1;
    #1;
    check("rel_ready", 64'(o_ant_ready), 64'(1));
    send_ant(mk(FORWARD, 9, 2), 5'b00100, 5'b01000, 5);
    a = mk(FORWARD, 3, 4);
    a.path[0] = 5'd0; a.path[1] = 5'd2; a.path[2] = 5'd4; a.path[3] = 5'd1;
    send_ant(a, 5'b00010, 5'b00100, 0);
    a = mk(BACKWARD, 9, 3);
    a.path[0] = 5'd2; a.path[1] = 5'd3; a.path[2] = 5'd1;
    send_ant(a, 5'b10000, 5'b00000, 1);
    send_ant(mk(FORWARD, 9, 8), 5'b00100, 5'b01000, 0);
    send_ant(mk(FORWARD, 9, 1), 5'b01000, 5'b00001, 0);
    check("two_drops", 64'(o_drop_count), 64'(2));
    send_ant(mk(FORWARD, 7, 0), 5'b00001, 5'b00000, 0);
    send_ant(mk(BACKWARD, 7, 0), 5'b00010, 5'b00100, 0);
    send_ant(mk(BACKWARD, 7, 1), 5'b00010, 5'b00100, 2);
    send_ant(mk(FORWARD, 7, 7), 5'b10000, 5'b00010, 0);
    for (int k = 0; k < 80; k++) begin
      a = '0;
      a.ant_type = ant_type_e'($urandom_range(0, 1));
      a.src = node_t'($urandom);
      a.dest = ($urandom_range(0, 3) == 0) ? node_t'(3) : node_t'($urandom);
      a.hop = hop_t'($urandom_range(0, 8));
      for (int i = 0; i < MAX_HOPS_PKG; i++) a.path[i] = node_t'($urandom_range(0, 4));
      inp = node_t'(1 << $urandom_range(0, 4));
      ans = ($urandom_range(0, 5) == 0) ? node_t'(0) : node_t'(1 << $urandom_range(0, 4));
      send_ant(a, inp, ans, $urandom_range(0, 3));
    end
    for (int k = 0; k < 260; k++) send_ant(mk(FORWARD, 9, 8), 5'b00100, 5'b01000, 0);
    check("sat_drops", 64'(o_drop_count), 64'(255));
    @(negedge i_clk);
    i_ant_valid = 1; i_ant = mk(FORWARD, 3, 2); i_in_port = 5'b00100; i_ant_ready = 0;
    @(posedge i_clk); #1;
    i_ant_valid = 0;
    @(posedge i_clk); #1;
    check("pre_rst_valid", 64'(o_ant_valid), 64'(1));
    @(negedge i_clk);
    i_reset_n = 0;
    #1;
    check("mid_rst_valid", 64'(o_ant_valid), 64'(0));
    check("mid_rst_cmd", 64'({o_rt_update, o_rt_calculate_neighbor}), 64'(0));
    check("mid_rst_ready", 64'(o_ant_ready), 64'(0));
    check("mid_rst_ant", 64'(o_ant), 64'(0));
    check("mid_rst_drops", 64'(o_drop_count), 64'(0));
    @(negedge i_clk);
    i_reset_n = 1;
    exp_drops = 0;
    #1;
    check("post_rst_ready", 64'(o_ant_ready), 64'(1));
    check("post_rst_drops", 64'(o_drop_count), 64'(0));
    @(posedge i_clk); #1;
    check("post_rst_novalid", 64'(o_ant_valid), 64'(0));
    send_ant(mk(FORWARD, 12, 3), 5'b00010, 5'b00100, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
